// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: owns PC load, imem request and IF/ID
// write/flush, resolving branch redirects, decode stalls and imem wait states.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_STALL   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic        ex_mem_pc_src,
    input  logic [31:0] ex_mem_npc,
    input  logic        id_stall,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        fetch_busy,
    output logic        stall_timeout
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES);
    localparam logic [9:0] WAIT_LAST = 10'(MAX_STALL - 1);

    state_t      state;
    logic [7:0]  boot_cnt;
    logic [31:0] redirect_q;
    logic [9:0]  wait_cnt;
    logic        waiting;
    logic        timeout;

    // A wait cycle is any cycle with an outstanding request and no data.
    assign waiting = imem_req && !imem_ready;
    assign timeout = waiting && (wait_cnt == WAIT_LAST);

    always_comb begin
        imem_req    = 1'b0;
        pc_we       = 1'b0;
        pc_next     = 32'd0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        fetch_busy  = 1'b0;
        case (state)
            S_BOOT: begin
                fetch_busy = 1'b1;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (ex_mem_pc_src) begin
                    // Redirect beats a decode stall: the wrong-path slot is flushed.
                    if_id_flush = 1'b1;
                    if (imem_ready) begin
                        pc_we   = 1'b1;
                        pc_next = ex_mem_npc;
                    end
                end else if (id_stall) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                end else if (imem_ready) begin
                    pc_we    = 1'b1;
                    pc_next  = pc_plus4;
                    if_id_we = 1'b1;
                end
            end
            S_REDIR: begin
                imem_req    = 1'b1;
                if_id_flush = 1'b1;
                fetch_busy  = 1'b1;
                if (imem_ready) begin
                    pc_we   = 1'b1;
                    pc_next = redirect_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            boot_cnt      <= 8'd0;
            redirect_q    <= 32'd0;
            wait_cnt      <= 10'd0;
            stall_timeout <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    wait_cnt <= 10'd0;
                    if (boot_cnt == BOOT_LAST) begin
                        state <= S_FETCH;
                    end else begin
                        boot_cnt <= boot_cnt + 8'd1;
                    end
                end
                S_FETCH, S_REDIR: begin
                    if (imem_ready) begin
                        wait_cnt <= 10'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                    // Timeout outranks every other transition out of these states.
                    if (timeout) begin
                        state         <= S_HALT;
                        stall_timeout <= 1'b1;
                    end else if (state == S_FETCH && ex_mem_pc_src && !imem_ready) begin
                        redirect_q <= ex_mem_npc;
                        state      <= S_REDIR;
                    end else if (state == S_REDIR && imem_ready) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected output vectors are queued as each
// step is driven and popped for comparison while the inputs are stable.
`timescale 1ns/100ps
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_plus4;
    logic        ex_mem_pc_src;
    logic [31:0] ex_mem_npc;
    logic        id_stall;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        if_id_we;
    logic        if_id_flush;
    logic        fetch_busy;
    logic        stall_timeout;

    logic [37:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          errors;
    logic [31:0] pc;

    fetch_ctrl #(.BOOT_CYCLES(2), .MAX_STALL(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_plus4      (pc_plus4),
        .ex_mem_pc_src (ex_mem_pc_src),
        .ex_mem_npc    (ex_mem_npc),
        .id_stall      (id_stall),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc_we         (pc_we),
        .pc_next       (pc_next),
        .if_id_we      (if_id_we),
        .if_id_flush   (if_id_flush),
        .fetch_busy    (fetch_busy),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: req, pc_we, pc_next, if_id_we, flush, busy, timeout
    function automatic logic [37:0] pack(input logic req, input logic we, input logic [31:0] nxt,
                                         input logic idwe, input logic flush, input logic busy,
                                         input logic to);
        return {req, we, nxt, idwe, flush, busy, to};
    endfunction

    task automatic check_out();
        logic [37:0] obs;
        logic [37:0] e;
        string       t;
        obs = pack(imem_req, pc_we, pc_next, if_id_we, if_id_flush, fetch_busy, stall_timeout);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic src, input logic [31:0] npc,
                        input logic stall, input logic rdy, input logic [37:0] e);
        ex_mem_pc_src = src;
        ex_mem_npc    = npc;
        id_stall      = stall;
        imem_ready    = rdy;
        pc_plus4      = pc + 32'd4;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_out();
        @(negedge clk);
    endtask

    // Sequential fetch with a ready memory; the bench tracks the PC itself.
    task automatic fetch_ok(input string tag);
        step(tag, 1'b0, 32'd0, 1'b0, 1'b1, pack(1, 1, pc + 32'd4, 1, 0, 0, 0));
        pc = pc + 32'd4;
    endtask

    // Short mid-cycle reset pulse; outputs must fall back without a clock edge.
    task automatic reset_pulse(input string tag);
        #3;
        rst_n = 1'b0;
        exp_q.push_back(pack(0, 0, 32'd0, 0, 0, 1, 0));
        tag_q.push_back(tag);
        #0.5;
        check_out();
        #0.5;
        rst_n = 1'b1;
        pc = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        pc            = 32'd0;
        rst_n         = 1'b0;
        ex_mem_pc_src = 1'b1;
        ex_mem_npc    = 32'h1234;
        id_stall      = 1'b0;
        imem_ready    = 1'b1;
        pc_plus4      = 32'd4;
        exp_q.push_back(pack(0, 0, 32'd0, 0, 0, 1, 0));
        tag_q.push_back("reset_state");
        #1;
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        step("boot_pre_edge1", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        step("boot_after_edge1", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        step("boot_after_edge2", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        fetch_ok("fetch_pc4");
        fetch_ok("fetch_pc8");
        fetch_ok("fetch_pc12");

        for (int i = 0; i < 3; i++) begin
            step("id_stall_hold", 0, 0, 1, 1, pack(1, 0, 0, 0, 0, 0, 0));
        end
        fetch_ok("resume_after_stall");

        step("redirect_ready", 1, 32'h40, 0, 1, pack(1, 1, 32'h40, 0, 1, 0, 0));
        pc = 32'h40;
        fetch_ok("fetch_after_redirect");
        step("redirect_beats_stall", 1, 32'h60, 1, 1, pack(1, 1, 32'h60, 0, 1, 0, 0));
        pc = 32'h60;
        fetch_ok("fetch_after_redirect_stall");

        step("redirect_wait_enter", 1, 32'h80, 0, 0, pack(1, 0, 0, 0, 1, 0, 0));
        step("redir_wait1", 0, 0, 0, 0, pack(1, 0, 0, 0, 1, 1, 0));
        step("redir_ignore_src", 1, 32'h100, 1, 0, pack(1, 0, 0, 0, 1, 1, 0));
        step("redir_wait3", 0, 0, 0, 0, pack(1, 0, 0, 0, 1, 1, 0));
        step("redir_wait4", 0, 0, 0, 0, pack(1, 0, 0, 0, 1, 1, 0));
        step("redir_release", 0, 0, 0, 1, pack(1, 1, 32'h80, 0, 1, 1, 0));
        pc = 32'h80;
        fetch_ok("fetch_redir_target_plus4");

        for (int i = 0; i < 15; i++) begin
            step("wait_below_limit", 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 0));
        end
        fetch_ok("fetch_after_15_waits");

        step("redirect_to_top", 1, 32'hFFFF_FFFC, 0, 1, pack(1, 1, 32'hFFFF_FFFC, 0, 1, 0, 0));
        pc = 32'hFFFF_FFFC;
        fetch_ok("pc_wrap_passthrough");

        for (int i = 0; i < 16; i++) begin
            step("wait_to_limit", 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 0));
        end
        step("halt_after_timeout", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 1));
        step("halt_ignores_inputs", 1, 32'h200, 0, 1, pack(0, 0, 0, 0, 0, 0, 1));

        reset_pulse("reset_from_halt");
        step("boot2_after_edge1", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        step("boot2_after_edge2", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        fetch_ok("fetch2_pc4");
        step("redirect2_wait_enter", 1, 32'h300, 0, 0, pack(1, 0, 0, 0, 1, 0, 0));
        step("redir2_wait", 0, 0, 0, 0, pack(1, 0, 0, 0, 1, 1, 0));

        reset_pulse("reset_from_redir");
        step("boot3_after_edge1", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        step("boot3_after_edge2", 0, 0, 0, 1, pack(0, 0, 0, 0, 0, 1, 0));
        fetch_ok("fetch3_pc4_no_stale_redirect");
        fetch_ok("fetch3_pc8");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
